// File: rtl/ram_io_responder.sv
// Byte-serial bus target: byte RAM plus an IO window with TX/RX FIFOs.
// Optional RAM_INIT_EN preloads the RAM in simulation.

module ram_io_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic       push_ok
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ram_io_responder #(
  parameter int    ADDR_WIDTH = 17,
  parameter int    FIFO_DEPTH = 8,
  parameter string INIT_FILE  = "test.data"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        io_buffer_full
);
  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [15:0] OFF_DATA = 16'h0000;
  localparam logic [15:0] OFF_STAT = 16'h0004;
  localparam string unused_init_file = INIT_FILE;

  logic [7:0]            ram [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  io_sel;
  logic                  io_data;
  logic                  io_stat;
  logic                  ram_we;
  logic                  tx_push;
  logic                  tx_push_ok;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  rx_pop;
  logic                  rx_push_ok;
  logic                  rx_full;
  logic                  rx_empty;
  logic [7:0]            rx_head;
  logic                  tx_overflow;
  logic [7:0]            ram_q;
  logic                  ram_rd_q;
  logic [7:0]            io_q;
  logic [7:0]            io_next;
  logic                  unused_a;

  assign unused_a = ^mem_a;
  assign idx      = mem_a[ADDR_WIDTH-1:0];
  assign io_sel   = (mem_a[17:16] == 2'b11);
  assign io_data  = io_sel & (mem_a[15:0] == OFF_DATA);
  assign io_stat  = io_sel & (mem_a[15:0] == OFF_STAT);
  assign ram_we   = rdy & mem_wr & ~io_sel;
  assign tx_push  = rdy & mem_wr & io_data;
  assign rx_pop   = rdy & ~mem_wr & io_data;

  assign tx_valid       = ~tx_empty;
  assign io_buffer_full = tx_full;
  assign rx_ready       = ~rx_full;

`ifdef RAM_INIT_EN
  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = 8'h00;
  end
`endif

  ram_io_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_push),
    .pop     (tx_ready),
    .din     (mem_wdata),
    .dout    (tx_data),
    .full    (tx_full),
    .empty   (tx_empty),
    .push_ok (tx_push_ok)
  );

  ram_io_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_valid),
    .pop     (rx_pop),
    .din     (rx_data),
    .dout    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .push_ok (rx_push_ok)
  );

  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= mem_wdata;
    if (rdy)    ram_q <= ram[idx];
  end

  always_comb begin
    io_next = 8'h00;
    if (!mem_wr) begin
      unique case (1'b1)
        io_data: io_next = rx_empty ? 8'h00 : rx_head;
        io_stat: io_next = {5'b0, tx_overflow, tx_full, ~rx_empty};
        default: io_next = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_rd_q <= 1'b0;
      io_q     <= 8'h00;
    end else if (rdy) begin
      ram_rd_q <= ~mem_wr & ~io_sel;
      io_q     <= io_next;
    end
  end

  assign mem_rdata = ram_rd_q ? ram_q : io_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_overflow <= 1'b0;
    end else if (rdy & mem_wr & io_stat) begin
      tx_overflow <= 1'b0;
    end else if (tx_push & ~tx_push_ok) begin
      tx_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: bus reads and TX drain
// are checked by monitors popping expectation queues.

module tb_ram_io_responder;
  localparam logic [31:0] DATA = 32'h0003_0000;
  localparam logic [31:0] STAT = 32'h0003_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_wdata = '0;
  logic [7:0]  mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        io_buffer_full;
  logic        chk = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  ram_io_responder #(
    .ADDR_WIDTH(17),
    .FIFO_DEPTH(8),
    .INIT_FILE("test.data")
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .io_buffer_full (io_buffer_full)
  );

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h", name, got, want);
    end
  endtask

  task automatic cyc(input logic [31:0] a, input logic wr,
                     input logic [7:0] wd, input logic r,
                     input logic c, input logic [7:0] e);
    mem_a = a;
    mem_wr = wr;
    mem_wdata = wd;
    rdy = r;
    chk = c;
    if (c) exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] e);
    cyc(a, 1'b0, 8'h00, 1'b1, 1'b1, e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    cyc(a, 1'b1, d, 1'b1, 1'b1, 8'h00);
  endtask

  // Bus monitor: one expectation per checked cycle, sampled after the edge.
  initial begin
    logic l;
    forever begin
      @(posedge clk);
      l = chk && !rst;
      #1;
      if (l) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rdata: got %02h want none queued", mem_rdata);
        end else begin
          check("rdata", mem_rdata, exp_q.pop_front());
        end
      end
    end
  end

  // TX monitor: sample the head just before the edge that pops it.
  always @(negedge clk) begin
    #3;
    if (!rst && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL tx_data: got %02h want none queued", tx_data);
      end else begin
        check("tx_data", tx_data, tx_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdata", mem_rdata, 8'h00);
    check("rst_tx_valid", 8'(tx_valid), 8'h00);
    check("rst_rx_ready", 8'(rx_ready), 8'h01);
    check("rst_full", 8'(io_buffer_full), 8'h00);
    rst = 1'b0;
    rd(STAT, 8'h00);

    wr(32'h100, 8'hA5);
    wr(32'h101, 8'h5A);
    wr(32'h102, 8'h3C);
    wr(32'h103, 8'hC3);
    wr(32'h104, 8'h77);
    rd(32'h104, 8'h77);
    rd(32'h100, 8'hA5);
    rd(32'h101, 8'h5A);
    rd(32'h102, 8'h3C);
    rd(32'h103, 8'hC3);

    repeat (3) cyc(32'h100, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC3);
    rd(32'h100, 8'hA5);
    rd(32'hF000_0101, 8'h5A);
    rd(32'h0003_0008, 8'h00);

    for (int i = 0; i < 9; i++) begin
      wr(DATA, 8'(8'h41 + i));
      if (i == 6) check("full_at7", 8'(io_buffer_full), 8'h00);
      if (i == 7) check("full_at8", 8'(io_buffer_full), 8'h01);
    end
    rd(STAT, 8'h06);
    for (int i = 0; i < 8; i++) tx_q.push_back(8'(8'h41 + i));
    tx_ready = 1'b1;
    idle(10);
    tx_ready = 1'b0;
    check("tx_drained", 8'(tx_q.size()), 8'h00);
    check("tx_valid_empty", 8'(tx_valid), 8'h00);
    rd(STAT, 8'h04);
    wr(STAT, 8'hFF);
    rd(STAT, 8'h00);

    rx_data = 8'h11;
    rx_valid = 1'b1;
    idle(1);
    rx_data = 8'h22;
    idle(1);
    rx_valid = 1'b0;
    rd(DATA, 8'h11);
    rd(STAT, 8'h01);
    rd(DATA, 8'h22);
    rd(STAT, 8'h00);
    rd(DATA, 8'h00);

    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'(8'hB0 + i);
      idle(1);
    end
    rx_valid = 1'b0;
    check("rx_full", 8'(rx_ready), 8'h00);
    for (int i = 0; i < 8; i++) rd(DATA, 8'(8'hB0 + i));
    rd(DATA, 8'h00);
    check("rx_ready_back", 8'(rx_ready), 8'h01);

    for (int i = 0; i < 8; i++) begin
      wr(DATA, 8'(8'h50 + i));
      tx_q.push_back(8'(8'h50 + i));
    end
    check("full_before", 8'(io_buffer_full), 8'h01);
    tx_q.push_back(8'h99);
    tx_ready = 1'b1;
    wr(DATA, 8'h99);
    tx_ready = 1'b0;
    check("full_after", 8'(io_buffer_full), 8'h01);
    rd(STAT, 8'h02);
    tx_ready = 1'b1;
    idle(12);
    tx_ready = 1'b0;
    check("tx_drained2", 8'(tx_q.size()), 8'h00);

    for (int i = 0; i < 4; i++) begin
      wr(DATA, 8'(8'h61 + i));
      tx_q.push_back(8'(8'h61 + i));
    end
    rd(32'h100, 8'hA5);
    rx_data = 8'hC0;
    rx_valid = 1'b1;
    idle(9);
    check("rx_full2", 8'(rx_ready), 8'h00);
    tx_ready = 1'b1;
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tx_valid", 8'(tx_valid), 8'h00);
    check("arst_rx_ready", 8'(rx_ready), 8'h01);
    check("arst_rdata", mem_rdata, 8'h00);
    check("arst_tx_left", 8'(tx_q.size()), 8'h02);
    tx_q.delete();
    @(negedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rst = 1'b0;
    rd(32'h100, 8'hA5);
    rd(STAT, 8'h00);
    check("post_tx_valid", 8'(tx_valid), 8'h00);
    idle(2);
    check("exp_q_empty", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
